// File: rtl/prbs_rx_checker.sv
// Receive-side PRBS-7 / PRBS-13 checker: self-synchronises to the incoming stream, confirms lock,
// then counts checked bits and bit errors. Define PRBS_CHECK_SYNC_LOSS_EN for windowed sync-loss re-hunt.
module prbs_rx_checker #(
    parameter int VERIFY_LEN = 16,
    parameter int LOSS_WIN   = 64,
    parameter int LOSS_THR   = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        control,
    input  logic        clear,
    input  logic        rx_valid,
    input  logic        rx_bit,
    output logic        locked,
    output logic        error_pulse,
    output logic        sync_loss,
    output logic [12:0] error_count,
    output logic [31:0] bit_count
);
    localparam int VW = $clog2(VERIFY_LEN + 1);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCKED
    } state_t;

    state_t        state, state_next;
    logic [12:0]   sr, sr_next;
    logic [3:0]    seed_cnt, seed_next;
    logic [VW-1:0] verify_cnt, verify_next;
    logic          ctrl_q;
    logic          predicted, mismatch, hist_zero, seed_done;
    logic          count_bit, count_err, loss_hit;

    generate
        if (VERIFY_LEN < 1 || LOSS_WIN < 2 || LOSS_THR < 1) begin : g_bad_params
            $error("prbs_rx_checker: illegal parameter values");
        end
    endgenerate

    always_comb begin
        predicted = control ? (sr[12] ^ sr[11] ^ sr[10] ^ sr[7]) : (sr[6] ^ sr[5]);
        hist_zero = control ? (sr == 13'd0) : (sr[6:0] == 7'd0);
        seed_done = control ? (seed_cnt == 4'd12) : (seed_cnt == 4'd6);
        mismatch  = (rx_bit != predicted);
    end

    // An all-zero history predicts 0 forever, so zeros received over it never advance verification.
    always_comb begin
        state_next  = state;
        sr_next     = sr;
        seed_next   = seed_cnt;
        verify_next = verify_cnt;
        count_bit   = 1'b0;
        count_err   = 1'b0;
        if (clear) begin
            state_next  = HUNT;
            seed_next   = '0;
            verify_next = '0;
        end else if (control != ctrl_q) begin
            state_next  = HUNT;
            seed_next   = '0;
            verify_next = '0;
            if (rx_valid) begin
                sr_next = {sr[11:0], rx_bit};
            end
        end else if (rx_valid) begin
            case (state)
                HUNT: begin
                    sr_next = {sr[11:0], rx_bit};
                    if (seed_done) begin
                        state_next  = VERIFY;
                        seed_next   = '0;
                        verify_next = '0;
                    end else begin
                        seed_next = seed_cnt + 4'd1;
                    end
                end
                VERIFY: begin
                    sr_next = {sr[11:0], rx_bit};
                    if (mismatch) begin
                        state_next  = HUNT;
                        seed_next   = '0;
                        verify_next = '0;
                    end else if (!hist_zero) begin
                        if (verify_cnt == VW'(VERIFY_LEN - 1)) begin
                            state_next  = LOCKED;
                            verify_next = '0;
                        end else begin
                            verify_next = verify_cnt + VW'(1);
                        end
                    end
                end
                LOCKED: begin
                    // Shifting the prediction keeps a channel error out of later predictions.
                    sr_next   = {sr[11:0], predicted};
                    count_bit = 1'b1;
                    count_err = mismatch;
                    if (loss_hit) begin
                        state_next = HUNT;
                        seed_next  = '0;
                    end
                end
                default: begin
                    state_next = HUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= HUNT;
            sr         <= '0;
            seed_cnt   <= '0;
            verify_cnt <= '0;
            ctrl_q     <= 1'b0;
        end else begin
            state      <= state_next;
            sr         <= sr_next;
            seed_cnt   <= seed_next;
            verify_cnt <= verify_next;
            ctrl_q     <= control;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            locked      <= 1'b0;
            error_pulse <= 1'b0;
            error_count <= '0;
            bit_count   <= '0;
        end else begin
            locked      <= (state_next == LOCKED);
            error_pulse <= count_err;
            if (clear) begin
                error_count <= '0;
                bit_count   <= '0;
            end else begin
                if (count_bit && bit_count != '1) begin
                    bit_count <= bit_count + 32'd1;
                end
                if (count_err && error_count != '1) begin
                    error_count <= error_count + 13'd1;
                end
            end
        end
    end

`ifdef PRBS_CHECK_SYNC_LOSS_EN
    localparam int WW = $clog2(LOSS_WIN);
    localparam int EW = $clog2(LOSS_THR + 1);

    logic [WW-1:0] win_cnt;
    logic [EW-1:0] win_err;

    assign loss_hit = (state == LOCKED) && rx_valid && !clear && (control == ctrl_q)
                      && mismatch && (win_err == EW'(LOSS_THR - 1));

    // Window restarts on every LOSS_WIN checked bits and whenever LOCKED is entered or left.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt   <= '0;
            win_err   <= '0;
            sync_loss <= 1'b0;
        end else begin
            sync_loss <= loss_hit;
            if (state != LOCKED || state_next != LOCKED) begin
                win_cnt <= '0;
                win_err <= '0;
            end else if (rx_valid) begin
                if (win_cnt == WW'(LOSS_WIN - 1)) begin
                    win_cnt <= '0;
                    win_err <= '0;
                end else begin
                    win_cnt <= win_cnt + WW'(1);
                    win_err <= win_err + EW'(mismatch);
                end
            end
        end
    end
`else
    assign loss_hit  = 1'b0;
    assign sync_loss = 1'b0;
`endif

endmodule

// File: tb/tb_prbs_rx_checker.sv
// Self-checking bench for prbs_rx_checker: directed scenarios plus a randomized run
// compared against a bit-history reference model of the checker's rules.
module tb_prbs_rx_checker;
    localparam int     VERIFY_LEN = 16;
    localparam int     LOSS_WIN   = 64;
    localparam int     LOSS_THR   = 8;
    localparam int     MAX_ERR    = 8191;
    localparam longint MAX_BITS   = 64'h0000_0000_FFFF_FFFF;
    localparam int     M_HUNT     = 0;
    localparam int     M_VERIFY   = 1;
    localparam int     M_LOCKED   = 2;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b1;
    logic        control  = 1'b0;
    logic        clear    = 1'b0;
    logic        rx_valid = 1'b0;
    logic        rx_bit   = 1'b0;
    logic        locked;
    logic        error_pulse;
    logic        sync_loss;
    logic [12:0] error_count;
    logic [31:0] bit_count;

    int tests_run    = 0;
    int tests_failed = 0;

    bit     gen_q[$];
    bit     m_hist[$];
    int     m_state;
    int     m_seed;
    int     m_vcnt;
    bit     m_ctrl_q;
    bit     exp_locked;
    bit     exp_pulse;
    bit     exp_loss;
    int     exp_err;
    longint exp_bits;
`ifdef PRBS_CHECK_SYNC_LOSS_EN
    int     m_win;
    int     m_werr;
`endif

    prbs_rx_checker #(
        .VERIFY_LEN(VERIFY_LEN),
        .LOSS_WIN  (LOSS_WIN),
        .LOSS_THR  (LOSS_THR)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .control    (control),
        .clear      (clear),
        .rx_valid   (rx_valid),
        .rx_bit     (rx_bit),
        .locked     (locked),
        .error_pulse(error_pulse),
        .sync_loss  (sync_loss),
        .error_count(error_count),
        .bit_count  (bit_count)
    );

    always #5 clock = ~clock;

    // Transmit-side pattern source: index 0 is the newest bit.
    task automatic gen_seed();
        gen_q.delete();
        for (int i = 0; i < 13; i++) gen_q.push_back(1'($urandom_range(0, 1)));
        gen_q[0] = 1'b1;
    endtask

    function automatic bit gen_next();
        bit b;
        b = control ? (gen_q[12] ^ gen_q[11] ^ gen_q[10] ^ gen_q[7]) : (gen_q[6] ^ gen_q[5]);
        gen_q.push_front(b);
        void'(gen_q.pop_back());
        return b;
    endfunction

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < 13; i++) m_hist.push_back(1'b0);
        m_state    = M_HUNT;
        m_seed     = 0;
        m_vcnt     = 0;
        m_ctrl_q   = 1'b0;
        exp_locked = 1'b0;
        exp_pulse  = 1'b0;
        exp_loss   = 1'b0;
        exp_err    = 0;
        exp_bits   = 0;
`ifdef PRBS_CHECK_SYNC_LOSS_EN
        m_win      = 0;
        m_werr     = 0;
`endif
    endtask

    task automatic model_push(input bit b);
        m_hist.push_front(b);
        void'(m_hist.pop_back());
    endtask

    task automatic model_step(input bit v, input bit b, input bit clr);
        int n;
        int ones;
        bit pred;
        exp_pulse = 1'b0;
        exp_loss  = 1'b0;
        n = control ? 13 : 7;
        pred = control ? (m_hist[12] ^ m_hist[11] ^ m_hist[10] ^ m_hist[7]) : (m_hist[6] ^ m_hist[5]);
        if (clr) begin
            exp_err  = 0;
            exp_bits = 0;
            m_state  = M_HUNT;
            m_seed   = 0;
            m_vcnt   = 0;
        end else if (control != m_ctrl_q) begin
            m_state = M_HUNT;
            m_seed  = 0;
            m_vcnt  = 0;
            if (v) model_push(b);
        end else if (v) begin
            if (m_state == M_HUNT) begin
                model_push(b);
                m_seed++;
                if (m_seed == n) begin
                    m_state = M_VERIFY;
                    m_seed  = 0;
                    m_vcnt  = 0;
                end
            end else if (m_state == M_VERIFY) begin
                ones = 0;
                for (int i = 0; i < n; i++) ones += int'(m_hist[i]);
                model_push(b);
                if (b != pred) begin
                    m_state = M_HUNT;
                    m_seed  = 0;
                end else if (ones != 0) begin
                    m_vcnt++;
                    if (m_vcnt == VERIFY_LEN) begin
                        m_state = M_LOCKED;
                        m_vcnt  = 0;
                    end
                end
            end else begin
                model_push(pred);
                if (exp_bits < MAX_BITS) exp_bits++;
                if (b != pred) begin
                    exp_pulse = 1'b1;
                    if (exp_err < MAX_ERR) exp_err++;
                end
`ifdef PRBS_CHECK_SYNC_LOSS_EN
                m_win++;
                if (b != pred) m_werr++;
                if (b != pred && m_werr == LOSS_THR) begin
                    exp_loss = 1'b1;
                    m_state  = M_HUNT;
                    m_seed   = 0;
                end else if (m_win == LOSS_WIN) begin
                    m_win  = 0;
                    m_werr = 0;
                end
`endif
            end
        end
        m_ctrl_q   = control;
        exp_locked = (m_state == M_LOCKED);
`ifdef PRBS_CHECK_SYNC_LOSS_EN
        if (m_state != M_LOCKED) begin
            m_win  = 0;
            m_werr = 0;
        end
`endif
    endtask

    task automatic applyStimulus(input bit v, input bit b, input bit clr);
        rx_valid = v;
        rx_bit   = b;
        clear    = clr;
        model_step(v, b, clr);
        @(posedge clock);
        #1;
    endtask

    task automatic lock_stream(input bit ctrl);
        control = ctrl;
        applyStimulus(1'b0, 1'b0, 1'b1);
        gen_seed();
        for (int i = 0; i < (ctrl ? 13 : 7) + VERIFY_LEN; i++) applyStimulus(1'b1, gen_next(), 1'b0);
    endtask

    task automatic test_reset();
        model_reset();
        #1 reset_n = 1'b0;
        #3;
        tests_run++;
        if ({locked, error_pulse, sync_loss} !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL reset_flags: got %b expected 000", {locked, error_pulse, sync_loss});
        end
        tests_run++;
        if (error_count !== 13'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_error_count: got %0d expected 0", error_count);
        end
        tests_run++;
        if (bit_count !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_bit_count: got %0d expected 0", bit_count);
        end
        @(posedge clock);
        #1 reset_n = 1'b1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (locked !== 1'b0 || bit_count !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_idle: got locked=%b bits=%0d expected 0/0", locked, bit_count);
        end
    endtask

    task automatic test_prbs7_lock();
        control = 1'b0;
        gen_seed();
        for (int i = 1; i <= 23; i++) begin
            applyStimulus(1'b1, gen_next(), 1'b0);
            if (i == 22) begin
                tests_run++;
                if (locked !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL prbs7_early_lock: got %b expected 0 at bit 22", locked);
                end
            end
        end
        tests_run++;
        if (locked !== 1'b1 || bit_count !== 32'd0) begin
            tests_failed++;
            $display("[TB] FAIL prbs7_lock: got locked=%b bits=%0d expected 1/0", locked, bit_count);
        end
        for (int i = 0; i < 100; i++) applyStimulus(1'b1, gen_next(), 1'b0);
        tests_run++;
        if (bit_count !== 32'd100) begin
            tests_failed++;
            $display("[TB] FAIL prbs7_bit_count: got %0d expected 100", bit_count);
        end
        tests_run++;
        if (error_count !== 13'd0 || locked !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL prbs7_clean: got err=%0d locked=%b expected 0/1", error_count, locked);
        end
    endtask

    task automatic test_prbs13_single_error();
        int pulses;
        bit b;
        pulses = 0;
        lock_stream(1'b1);
        tests_run++;
        if (locked !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL prbs13_lock: got %b expected 1 at bit 29", locked);
        end
        for (int k = 1; k <= 100; k++) begin
            b = gen_next();
            applyStimulus(1'b1, (k == 50) ? ~b : b, 1'b0);
            pulses += int'(error_pulse);
            if (k == 50) begin
                tests_run++;
                if (error_pulse !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL prbs13_pulse_at_50: got %b expected 1", error_pulse);
                end
            end
        end
        tests_run++;
        if (pulses != 1) begin
            tests_failed++;
            $display("[TB] FAIL prbs13_pulse_count: got %0d expected 1", pulses);
        end
        tests_run++;
        if (error_count !== 13'd1 || locked !== 1'b1 || bit_count !== 32'd100) begin
            tests_failed++;
            $display("[TB] FAIL prbs13_counts: got err=%0d locked=%b bits=%0d expected 1/1/100",
                     error_count, locked, bit_count);
        end
    endtask

    task automatic test_verify_flip();
        bit b;
        control = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b1);
        gen_seed();
        for (int i = 1; i <= 40; i++) begin
            b = gen_next();
            applyStimulus(1'b1, (i == 12) ? ~b : b, 1'b0);
            if (i == 23 || i == 34) begin
                tests_run++;
                if (locked !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL verify_flip_no_lock_bit%0d: got %b expected 0", i, locked);
                end
            end
            if (i == 35) begin
                tests_run++;
                if (locked !== 1'b1) begin
                    tests_failed++;
                    $display("[TB] FAIL verify_flip_relock: got %b expected 1 at bit 35", locked);
                end
            end
        end
        tests_run++;
        if (error_count !== 13'd0 || bit_count !== 32'd5) begin
            tests_failed++;
            $display("[TB] FAIL verify_flip_counts: got err=%0d bits=%0d expected 0/5", error_count, bit_count);
        end
    endtask

    task automatic test_sync_loss();
        bit flip[41];
        int nflip;
        int last;
        int p;
        int losses;
        bit b;
        nflip  = 0;
        last   = 0;
        losses = 0;
        for (int i = 0; i <= 40; i++) flip[i] = 1'b0;
        while (nflip < 8) begin
            p = int'($urandom_range(1, 40));
            if (!flip[p]) begin
                flip[p] = 1'b1;
                nflip++;
                if (p > last) last = p;
            end
        end
        lock_stream(1'b0);
        for (int k = 1; k <= 40; k++) begin
            b = gen_next();
            applyStimulus(1'b1, flip[k] ? ~b : b, 1'b0);
            losses += int'(sync_loss);
`ifdef PRBS_CHECK_SYNC_LOSS_EN
            if (k == last) begin
                tests_run++;
                if (sync_loss !== 1'b1 || locked !== 1'b0 || error_count !== 13'd8) begin
                    tests_failed++;
                    $display("[TB] FAIL sync_loss_event: got loss=%b locked=%b err=%0d expected 1/0/8",
                             sync_loss, locked, error_count);
                end
            end
`endif
        end
`ifdef PRBS_CHECK_SYNC_LOSS_EN
        tests_run++;
        if (losses != 1 || error_count !== 13'd8) begin
            tests_failed++;
            $display("[TB] FAIL sync_loss_total: got pulses=%0d err=%0d expected 1/8", losses, error_count);
        end
`else
        tests_run++;
        if (losses != 0 || locked !== 1'b1 || error_count !== 13'd8) begin
            tests_failed++;
            $display("[TB] FAIL no_sync_loss: got pulses=%0d locked=%b err=%0d expected 0/1/8",
                     losses, locked, error_count);
        end
`endif
    endtask

    task automatic test_saturation();
`ifndef PRBS_CHECK_SYNC_LOSS_EN
        lock_stream(1'b0);
        for (int k = 0; k < 8190; k++) applyStimulus(1'b1, ~gen_next(), 1'b0);
        tests_run++;
        if (error_count !== 13'd8190) begin
            tests_failed++;
            $display("[TB] FAIL sat_pre: got %0d expected 8190", error_count);
        end
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, ~gen_next(), 1'b0);
        tests_run++;
        if (error_count !== 13'd8191 || error_pulse !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sat_hold: got err=%0d pulse=%b expected 8191/1", error_count, error_pulse);
        end
        applyStimulus(1'b1, gen_next(), 1'b0);
        tests_run++;
        if (error_count !== 13'd8191 || bit_count !== 32'd8194 || locked !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL sat_after: got err=%0d bits=%0d locked=%b expected 8191/8194/1",
                     error_count, bit_count, locked);
        end
`endif
    endtask

    task automatic test_mid_stream();
        bit b;
        lock_stream(1'b0);
        for (int k = 1; k <= 10; k++) begin
            b = gen_next();
            applyStimulus(1'b1, (k == 3 || k == 7) ? ~b : b, 1'b0);
        end
        tests_run++;
        if (error_count !== 13'd2 || bit_count !== 32'd10) begin
            tests_failed++;
            $display("[TB] FAIL mid_pre_clear: got err=%0d bits=%0d expected 2/10", error_count, bit_count);
        end
        applyStimulus(1'b1, 1'($urandom_range(0, 1)), 1'b1);
        tests_run++;
        if (error_count !== 13'd0 || bit_count !== 32'd0 || locked !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_clear: got err=%0d bits=%0d locked=%b expected 0/0/0",
                     error_count, bit_count, locked);
        end
        for (int i = 1; i <= 23; i++) begin
            applyStimulus(1'b1, gen_next(), 1'b0);
            if (i == 22) begin
                tests_run++;
                if (locked !== 1'b0) begin
                    tests_failed++;
                    $display("[TB] FAIL mid_clear_hunt: got %b expected 0 at bit 22", locked);
                end
            end
        end
        for (int k = 1; k <= 5; k++) begin
            b = gen_next();
            applyStimulus(1'b1, (k == 2) ? ~b : b, 1'b0);
        end
        tests_run++;
        if (locked !== 1'b1 || error_count !== 13'd1 || bit_count !== 32'd5) begin
            tests_failed++;
            $display("[TB] FAIL mid_relock: got locked=%b err=%0d bits=%0d expected 1/1/5",
                     locked, error_count, bit_count);
        end
        rx_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        tests_run++;
        if ({locked, error_pulse, sync_loss, error_count, bit_count} !== 48'd0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset: got %h expected 0",
                     {locked, error_pulse, sync_loss, error_count, bit_count});
        end
        #2 reset_n = 1'b1;
        model_reset();
        applyStimulus(1'b0, 1'b0, 1'b0);
        lock_stream(1'b0);
        for (int k = 1; k <= 10; k++) begin
            b = gen_next();
            applyStimulus(1'b1, (k == 4) ? ~b : b, 1'b0);
        end
        control = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0);
        tests_run++;
        if (locked !== 1'b0 || error_count !== 13'd1 || bit_count !== 32'd10) begin
            tests_failed++;
            $display("[TB] FAIL control_toggle: got locked=%b err=%0d bits=%0d expected 0/1/10",
                     locked, error_count, bit_count);
        end
    endtask

    task automatic test_random();
        bit v;
        bit b;
        bit clr;
        control = 1'b0;
        gen_seed();
        for (int c = 0; c < 4000; c++) begin
            v   = ($urandom_range(0, 9) != 0);
            clr = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 799) == 0) begin
                control = ~control;
                gen_seed();
            end
            b = v ? gen_next() : 1'($urandom_range(0, 1));
            if (v && $urandom_range(0, 59) == 0) b = ~b;
            applyStimulus(v, b, clr);
            tests_run++;
            if ({locked, error_pulse, sync_loss, error_count, bit_count} !==
                {exp_locked, exp_pulse, exp_loss, exp_err[12:0], exp_bits[31:0]}) begin
                tests_failed++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", c,
                         {locked, error_pulse, sync_loss, error_count, bit_count},
                         {exp_locked, exp_pulse, exp_loss, exp_err[12:0], exp_bits[31:0]});
            end
        end
    endtask

    initial begin
        test_reset();
        test_prbs7_lock();
        test_prbs13_single_error();
        test_verify_flip();
        test_sync_loss();
        test_saturation();
        test_mid_stream();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
